// File: rtl/spi_led_regs_if.sv
// SPI pin bundle between an initiator and the LED register responder.
interface spi_led_regs_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_led_regs.sv
// SPI mode-0 responder for a 4-entry LED register file driving LED1..LED5.
// Define SPI_LED_BLINK_EN to build the blink prescaler and phase logic.
module spi_led_regs #(
  parameter int PSC_SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_led_regs_if.slave spi,
  output logic          LED1,
  output logic          LED2,
  output logic          LED3,
  output logic          LED4,
  output logic          LED5
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  sck_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic        rise_q;
  logic        fall_q;
  logic [4:0]  bcnt_q;
  logic [6:0]  sh_q;
  logic [7:0]  tx_q;
  logic        wr_q;
  logic [1:0]  addr_q;
  logic        miso_q;
  logic [4:0]  led_q;
  logic [4:0]  mask_q;
  logic [4:0]  out_q;
  logic [7:0]  rate_q;
  logic [3:0]  wcnt_q;
  logic        phase;
  logic        commit;
  logic [7:0]  cmd;
  logic [7:0]  rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi.spi_sck};
      cs_q   <= {cs_q[1:0], spi.spi_cs_n};
      mosi_q <= {mosi_q[0], spi.spi_mosi};
      rise_q <= sck_q[1] & ~sck_q[2];
      fall_q <= ~sck_q[1] & sck_q[2];
    end
  end

  assign cmd = {sh_q, mosi_q[1]};

  always_comb begin
    rdata = 8'h00;
    case (cmd[1:0])
      2'd0:    rdata = {3'b000, led_q};
      2'd1:    rdata = {3'b000, mask_q};
      2'd2:    rdata = rate_q;
      default: rdata = {wcnt_q, 3'b000, phase};
    endcase
  end

  assign commit = !cs_q[1] && rise_q && state_q == DATA &&
                  bcnt_q == 5'd15 && wr_q && addr_q != 2'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= 5'd0;
      sh_q    <= 7'd0;
      tx_q    <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= 2'd0;
      miso_q  <= 1'b0;
    end else if (cs_q[1]) begin
      state_q <= IDLE;
      bcnt_q  <= 5'd0;
      miso_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // only a real CS falling edge opens a frame
          if (cs_q[2]) state_q <= CMD;
          bcnt_q <= 5'd0;
          miso_q <= 1'b0;
        end
        CMD: begin
          if (rise_q) begin
            sh_q   <= cmd[6:0];
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd7) begin
              state_q <= DATA;
              wr_q    <= cmd[7];
              addr_q  <= cmd[1:0];
              tx_q    <= rdata;
            end
          end
        end
        DATA: begin
          if (rise_q) begin
            sh_q   <= cmd[6:0];
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd15) begin
              state_q <= DONE;
              miso_q  <= 1'b0;
            end
          end else if (fall_q) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
        DONE: state_q <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= 5'd0;
      mask_q <= 5'd0;
      rate_q <= 8'hFF;
      wcnt_q <= 4'd0;
      out_q  <= 5'd0;
    end else begin
      if (commit) begin
        case (addr_q)
          2'd0:    led_q  <= cmd[4:0];
          2'd1:    mask_q <= cmd[4:0];
          default: rate_q <= cmd;
        endcase
        wcnt_q <= wcnt_q + 4'd1;
      end
      out_q <= led_q ^ (mask_q & {5{phase}});
    end
  end

`ifdef SPI_LED_BLINK_EN
  localparam int PW = PSC_SHIFT + 8;

  logic [PW-1:0] psc_q;
  logic          phase_q;
  logic          tc;

  // (RATE+1)<<S - 1 is RATE in the top byte with all low bits set
  assign tc = (psc_q[PW-1:PSC_SHIFT] == rate_q) &&
              (&psc_q[PSC_SHIFT-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (tc) phase_q <= ~phase_q;
      if (tc || (commit && addr_q == 2'd2)) psc_q <= '0;
      else psc_q <= psc_q + PW'(1);
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  assign spi.spi_miso = miso_q;
  assign LED1 = out_q[0];
  assign LED2 = out_q[1];
  assign LED3 = out_q[2];
  assign LED4 = out_q[3];
  assign LED5 = out_q[4];

endmodule

// File: tb/tb_spi_led_regs.sv
// Directed scoreboard bench for spi_led_regs (PSC_SHIFT = 2).
// Blink checks run when SPI_LED_BLINK_EN is defined, steady checks otherwise.
module tb_spi_led_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic LED1, LED2, LED3, LED4, LED5;
  logic [4:0] leds;

  spi_led_regs_if spi();

  spi_led_regs #(.PSC_SHIFT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .spi  (spi),
    .LED1 (LED1),
    .LED2 (LED2),
    .LED3 (LED3),
    .LED4 (LED4),
    .LED5 (LED5)
  );

  always #5 clk = ~clk;
  assign leds = {LED5, LED4, LED3, LED2, LED1};

  int ncmp = 0;
  int nmis = 0;
  int cyc = 0;
  int c0 = 0;
  int wc = 0;
  logic [7:0] exp_q[$];
  logic [4:0] led_pre, led_post;
  logic [7:0] rxb;

`ifdef SPI_LED_BLINK_EN
  localparam logic [7:0] SM = 8'hFE;
`else
  localparam logic [7:0] SM = 8'hFF;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    ncmp++;
    if (exp_q.size() == 0) begin
      nmis++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic frame(input int nb, input logic [23:0] d);
    rxb = 8'h00;
    spi.spi_cs_n = 1'b0;
    for (int i = 0; i < nb; i++) begin
      spi.spi_mosi = d[nb-1-i];
      repeat (6) @(negedge clk);
      if (i >= 8 && i < 16) rxb = {rxb[6:0], spi.spi_miso};
      spi.spi_sck = 1'b1;
      if (i == 15) begin
        c0 = cyc;
        repeat (4) @(negedge clk);
        led_pre = leds;
        @(negedge clk);
        led_post = leds;
        @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      spi.spi_sck = 1'b0;
    end
    spi.spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    spi.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e,
                    input logic [7:0] m, input string tag);
    exp_q.push_back(e);
    frame(16, {8'h00, 6'b0, a, 8'h00});
    chk(tag, rxb & m);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    frame(16, {8'h00, 1'b1, 5'b0, a, v});
    if (a != 2'd3) wc = (wc + 1) % 16;
  endtask

  initial begin
    logic [4:0] v0;
    int c;
    int tg;
    spi.spi_sck = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h00);
    chk("rst_led", {3'b0, leds});
    exp_q.push_back(8'h00);
    chk("rst_miso", {7'b0, spi.spi_miso});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    rd(2'd2, 8'hFF, 8'hFF, "rst_rate");
    rd(2'd3, 8'h00, SM, "rst_status");

    wr(2'd0, 8'h15);
    exp_q.push_back(8'h00);
    chk("wr_led_pre", {3'b0, led_pre});
    exp_q.push_back(8'h15);
    chk("wr_led_lat", {3'b0, led_post});
    rd(2'd0, 8'h15, 8'hFF, "rb_led");
    exp_q.push_back(8'h00);
    chk("idle_miso", {7'b0, spi.spi_miso});
    rd(2'd3, {wc[3:0], 4'h0}, SM, "status_wc1");

    frame(12, 24'h000800);
    exp_q.push_back(8'h15);
    chk("abort_led", {3'b0, leds});
    exp_q.push_back(8'h00);
    chk("abort_miso", {7'b0, spi.spi_miso});
    rd(2'd3, {wc[3:0], 4'h0}, SM, "abort_wcnt");
    rd(2'd0, 8'h15, 8'hFF, "abort_next");

    frame(24, 24'h8103FF);
    wc = (wc + 1) % 16;
    rd(2'd1, 8'h03, 8'hFF, "ovr_mask");
    wr(2'd3, 8'h55);
    rd(2'd3, {wc[3:0], 4'h0}, SM, "stat_wr");
    wr(2'd2, 8'h5A);
    rd(2'd2, 8'h5A, 8'hFF, "rate_rw");

`ifdef SPI_LED_BLINK_EN
    wr(2'd1, 8'h1F);
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h01);
    v0 = led_post;
    ncmp++;
    assert (v0 === 5'h00 || v0 === 5'h1F) else begin
      nmis++;
      $error("FAIL blink_start: observed %h expected 00 or 1f", v0);
    end
    for (int k = 0; k < 40; k++) begin
      c = cyc - c0;
      tg = (c < 12) ? 0 : ((c - 12) / 8 + 1);
      exp_q.push_back({3'b0, v0 ^ {5{tg[0]}}});
      chk("blink", {3'b0, leds});
      @(negedge clk);
    end
    rd(2'd3, {wc[3:0], 4'h0}, SM, "blink_status");
`else
    wr(2'd1, 8'h1F);
    wr(2'd0, 8'h0A);
    exp_q.push_back(8'h0A);
    chk("steady_lat", {3'b0, led_post});
    for (int k = 0; k < 1100; k++) begin
      repeat (64) @(negedge clk);
      exp_q.push_back(8'h0A);
      chk("steady", {3'b0, leds});
    end
    rd(2'd3, {wc[3:0], 4'h0}, 8'hFF, "stat_nophase");
    rd(2'd1, 8'h1F, 8'hFF, "mask_store");
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    wc = 0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h00);
    chk("rst2_led", {3'b0, leds});
    exp_q.push_back(8'h00);
    chk("rst2_miso", {7'b0, spi.spi_miso});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h00);
    chk("rst2_led_rel", {3'b0, leds});
    rd(2'd2, 8'hFF, 8'hFF, "rst2_rate");
    rd(2'd3, 8'h00, 8'hFF, "rst2_status");
    rd(2'd0, 8'h00, 8'hFF, "rst2_ledreg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/spi_led_regs.md
# spi_led_regs

SPI mode-0 responder that gives an external SPI initiator (host MCU or bench) read/write access to a small LED control register file, and drives the five board LEDs from it. It is the receiving end of the host-to-board SPI link on the ICEstick SD-card design. It replaces free-running, fixed-rate LED blinking with host-programmed LED patterns, a blink mask and a blink rate. All SPI pins are oversampled in the system clock domain.

## Interface
- PSC_SHIFT, 8: blink half-period = (RATE+1) << PSC_SHIFT clk cycles; prescaler counter width = PSC_SHIFT+8.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock from initiator, asynchronous to clk, idle low.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  data from initiator, asynchronous.
- spi_miso  out  1  data to initiator, registered.
- LED1..LED5  out  1 each  LED drives, registered; LEDn = bit n-1.

## Operation
- Synchronisers: spi_sck, spi_cs_n and spi_mosi each pass through two flops. Edge detect compares the second stage against a third flop.
- Frame: 16 bits, MSB first, while CS is low.
  - Byte 0 (command): bit7 = 1 for write, 0 for read; bits[1:0] = address; bits[6:2] ignored.
  - Byte 1: write data (write command) or read data (read command).
- Sampling: MOSI is sampled on each synchronised SCK rising edge into a shift register. A 5-bit bit counter (0..16) saturates at 16.
- Registers:
  - addr 0 LED[4:0] (rw).
  - addr 1 MASK[4:0] (rw).
  - addr 2 RATE[7:0] (rw).
  - addr 3 STATUS (ro): bit0 = blink phase, bits[3:1] = 0, bits[7:4] = completed-write count mod 16.
  - Unused bits read 0.
- Write commit: happens on the 16th rising edge, only for a write command to addresses 0..2.
  - A write to addr 3 is ignored and does not increment the write count.
  - Writes to addr 0..2 increment the write count (wraps 15 → 0).
- Read path:
  - On the 8th rising edge, read data for the address is latched into the TX shift register.
  - On the 8th falling edge, MISO <= rdata[7].
  - On falling edges 9..15, MISO <= rdata[6..0].
  - MISO is 0 during byte 0, after bit 16, and whenever CS is high.
- States: IDLE (CS high), CMD (bits 0-7), DATA (bits 8-15), DONE (16 bits received; further SCK is ignored until CS rises).
  - IDLE→CMD on CS falling.
  - CMD→DATA after the 8th rising edge.
  - DATA→DONE after the 16th rising edge.
  - Any state→IDLE on CS rising.
- CS rising mid-frame aborts the frame: no write, bit counter reset to 0, MISO reset to 0.
- SCK edges seen while CS is high are ignored.
- Output: LEDn = LED[n-1] XOR (MASK[n-1] AND phase).

## Timing
- Reset values: LED = 0, MASK = 0, RATE = 0xFF, write count = 0, phase = 0, prescaler = 0, state = IDLE, all LED outputs = 0, spi_miso = 0.
- Let clk edge N be the first clk edge at which spi_sck is high at the pin.
  - The rising edge is detected at N+2.
  - A commit on the 16th rising edge updates the register at N+3 and the LED outputs at N+4.
  - Falling-edge MISO updates follow the same latency.
- SPI constraints:
  - SCK high and SCK low each ≥ 4 clk cycles.
  - CS falling ≥ 4 clk cycles before the first SCK rising edge.
  - CS high ≥ 4 clk cycles between frames.
  - MISO is valid ≥ 1 clk cycle before the next SCK rising edge under these limits.
- Prescaler:
  - Increments every clk.
  - At terminal count (RATE+1)<<PSC_SHIFT − 1 it clears and toggles phase.
  - A write to RATE clears the prescaler in the commit cycle; phase is unchanged.
- Simultaneous events:
  - A commit and a prescaler terminal count in the same cycle both take effect.
  - LED outputs reflect the new register and the new phase on the next cycle.
  - A STATUS read returns the count and phase as latched at the 8th rising edge.

## Configuration
- SPI_LED_BLINK_EN defined: prescaler and phase logic are present, and LEDs blink per MASK and RATE.
- SPI_LED_BLINK_EN not defined:
  - Prescaler and phase are removed; phase is constant 0.
  - LEDn = LED[n-1].
  - MASK and RATE remain readable and writable storage.
  - STATUS bit0 reads 0.

## Test plan
- Reset: assert rst_n low mid-blink, then release → all LEDs 0 and MISO 0; a read of addr 2 returns 0xFF and a read of addr 3 returns 0x00.
- Write-then-readback: write 0x80/0x15 → LED1, LED3, LED5 = 1 within 4 clk of the 16th SCK rising edge; read 0x00 returns 0x15; STATUS[7:4] = 1.
- Blink (macro defined), PSC_SHIFT = 2: write MASK = 0x1F, RATE = 0x01, LED = 0 → all LEDs toggle every 8 clk cycles, starting 8 cycles after the RATE commit.
- Abort: raise CS after 12 bits of write 0x80/0x0F → LED unchanged and write count unchanged; the next full frame is decoded correctly.
- Overrun and STATUS write: a 24-bit frame writing 0x81/0x03 followed by 0xFF → MASK = 0x03 and extra bits are ignored; a write to addr 3 leaves STATUS[7:4] unchanged.
- Macro undefined: write MASK = 0x1F, LED = 0x0A → LED2 and LED4 stay constant 1 for ≥ 2¹⁶ cycles; STATUS bit0 = 0.
